// File: rtl/rv_ctrl_pkg.sv
// Shared constants for the multi-cycle RV32I control path: opcodes, FSM
// state encodings and the mux-select codes driven onto the datapath.
package rv_ctrl_pkg;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_ALUWB    = 4'd7,
      S_EXECUTEI = 4'd8,
      S_JAL      = 4'd9,
      S_BEQ      = 4'd10
   } state_t;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2   = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/ctrl_next_state.sv
// Combinational next-state function of the multi-cycle control FSM.
// mem_ready arrives already qualified by the wait-enable setting.
module ctrl_next_state
   import rv_ctrl_pkg::*;
(
   input  state_t     state,
   input  logic [6:0] op,
   input  logic       mem_ready,
   output state_t     next
);

   always_comb begin
      next = S_FETCH;
      case (state)
         S_FETCH:    next = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            // Unknown opcodes fall back to FETCH so they behave as a NOP.
            if (op == OP_LW || op == OP_SW) next = S_MEMADR;
            else if (op == OP_R)            next = S_EXECUTER;
            else if (op == OP_I)            next = S_EXECUTEI;
            else if (op == OP_JAL)          next = S_JAL;
            else if (op == OP_BEQ)          next = S_BEQ;
            else                            next = S_FETCH;
         end
         S_MEMADR: begin
            if (op == OP_LW)      next = S_MEMREAD;
            else if (op == OP_SW) next = S_MEMWRITE;
            else                  next = S_FETCH;
         end
         S_MEMREAD:  next = mem_ready ? S_MEMWB : S_MEMREAD;
         S_MEMWB:    next = S_FETCH;
         S_MEMWRITE: next = mem_ready ? S_FETCH : S_MEMWRITE;
         S_EXECUTER: next = S_ALUWB;
         S_EXECUTEI: next = S_ALUWB;
         S_ALUWB:    next = S_FETCH;
         S_JAL:      next = S_ALUWB;
         S_BEQ:      next = S_FETCH;
         default:    next = S_FETCH;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multi-cycle RV32I core: state register plus Moore
// output decode, with branch resolution and memory wait-state handshaking.
module multicycle_ctrl_fsm
   import rv_ctrl_pkg::*;
#(
   parameter int WAIT_EN = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       adr_src,
   output logic       mem_write,
   output logic       ir_write,
   output logic [1:0] result_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic       reg_write,
   output logic [3:0] state_o
);

   state_t state;
   state_t next;
   state_t dec_state;
   logic   ready;
   logic   pc_update;
   logic   branch;

   assign ready = (WAIT_EN != 0) ? mem_ready : 1'b1;

   ctrl_next_state u_next (
      .state     (state),
      .op        (op),
      .mem_ready (ready),
      .next      (next)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= S_FETCH;
      else       state <= next;
   end

   // Outputs look like FETCH while reset is held, so nothing is strobed mid-instruction.
   assign dec_state = reset ? S_FETCH : state;

   always_comb begin
      pc_update  = 1'b0;
      branch     = 1'b0;
      adr_src    = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      result_src = RES_ALUOUT;
      alu_src_a  = SRCA_PC;
      alu_src_b  = SRCB_RS2;
      alu_op     = ALUOP_ADD;
      reg_write  = 1'b0;
      case (dec_state)
         S_FETCH: begin
            alu_src_a  = SRCA_PC;
            alu_src_b  = SRCB_FOUR;
            alu_op     = ALUOP_ADD;
            result_src = RES_ALU;
            ir_write   = ready;
            pc_update  = ready;
         end
         S_DECODE: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
            alu_op    = ALUOP_ADD;
         end
         S_MEMADR: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            alu_op    = ALUOP_ADD;
         end
         S_MEMREAD: begin
            adr_src    = 1'b1;
            result_src = RES_ALUOUT;
         end
         S_MEMWB: begin
            result_src = RES_DATA;
            reg_write  = 1'b1;
         end
         S_MEMWRITE: begin
            adr_src    = 1'b1;
            result_src = RES_ALUOUT;
            mem_write  = 1'b1;
         end
         S_EXECUTER: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_RS2;
            alu_op    = ALUOP_FUNCT;
         end
         S_EXECUTEI: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            alu_op    = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            result_src = RES_ALUOUT;
            reg_write  = 1'b1;
         end
         S_JAL: begin
            alu_src_a  = SRCA_OLDPC;
            alu_src_b  = SRCB_FOUR;
            alu_op     = ALUOP_ADD;
            result_src = RES_ALUOUT;
            pc_update  = 1'b1;
         end
         S_BEQ: begin
            alu_src_a  = SRCA_RS1;
            alu_src_b  = SRCB_RS2;
            alu_op     = ALUOP_SUB;
            result_src = RES_ALUOUT;
            branch     = 1'b1;
         end
         default: begin
            pc_update = 1'b0;
         end
      endcase
   end

   assign pc_write = pc_update | (branch & zero);
   assign state_o  = state;

endmodule
